layer0_scheduler: RTL and testbench

LAYER0_SCHEDULER -- requirements
Module: layer0_scheduler

---
 rtl/dpu_pkg.sv | 16 +
 rtl/layer0_scheduler.sv | 136 +++++++++++++
 tb/tb_layer0_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpu_pkg.sv
// Shared DPU definitions: scheduler FSM states and MAC count per output.
package dpu_pkg;

    localparam int MACS = 27;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CB,
        CAPT_CB,
        START,
        RUN,
        EMIT,
        ADVANCE
    } state_t;

endpackage

// File: rtl/layer0_scheduler.sv
// Layer-0 job scheduler: walks pixels x channels, feeds the MAC engine
// and presents each engine result on a valid/ready output port.
module layer0_scheduler #(
    parameter int MACS    = dpu_pkg::MACS,
    parameter int SCALE_W = 16,
    parameter int PIX_W   = 12,
    parameter int CH_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PIX_W-1:0]     cmd_num_pix,
    input  logic [CH_W-1:0]      cmd_num_ch,
    output logic [PIX_W+4:0]     act_addr,
    input  logic [7:0]           act_data,
    output logic [CH_W+4:0]      w_addr,
    input  logic [7:0]           w_data,
    output logic [CH_W-1:0]      cb_addr,
    input  logic [31:0]          cb_bias,
    input  logic [SCALE_W-1:0]   cb_scale,
    output logic                 eng_start,
    output logic [7:0]           eng_act,
    output logic [7:0]           eng_w,
    output logic [31:0]          eng_bias,
    output logic [SCALE_W-1:0]   eng_scale,
    input  logic [4:0]           eng_mac_index,
    input  logic                 eng_done,
    input  logic [7:0]           eng_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [PIX_W-1:0]     out_pix,
    output logic [CH_W-1:0]      out_ch,
    output logic                 busy,
    output logic                 job_done
);
    import dpu_pkg::*;

    localparam logic [PIX_W+4:0] MAC_A = (PIX_W+5)'(MACS);
    localparam logic [CH_W+4:0]  MAC_W = (CH_W+5)'(MACS);

    state_t           state, state_nx;
    logic [PIX_W-1:0] num_pix, pix;
    logic [CH_W-1:0]  num_ch, ch;
    logic             ch_last, last, cmd_zero;

    assign ch_last  = (ch == num_ch - CH_W'(1));
    assign last     = ch_last && (pix == num_pix - PIX_W'(1));
    assign cmd_zero = (cmd_num_pix == '0) || (cmd_num_ch == '0);

    assign act_addr = (PIX_W+5)'(pix) * MAC_A + (PIX_W+5)'(eng_mac_index);
    assign w_addr   = (CH_W+5)'(ch) * MAC_W + (CH_W+5)'(eng_mac_index);
    assign cb_addr  = ch;
    assign eng_act  = act_data;
    assign eng_w    = w_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        eng_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = !rst;
                if (cmd_valid && !rst)
                    state_nx = cmd_zero ? IDLE : LOAD_CB;
            end
            LOAD_CB: state_nx = CAPT_CB;
            CAPT_CB: state_nx = START;
            START: begin
                eng_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: if (eng_done) state_nx = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ADVANCE;
            end
            ADVANCE: state_nx = last ? IDLE : LOAD_CB;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_pix   <= '0;
            num_ch    <= '0;
            pix       <= '0;
            ch        <= '0;
            eng_bias  <= '0;
            eng_scale <= '0;
            out_data  <= '0;
            out_pix   <= '0;
            out_ch    <= '0;
            job_done  <= 1'b0;
        end else begin
            job_done <= 1'b0;
            if (state == IDLE && cmd_valid) begin
                num_pix  <= cmd_num_pix;
                num_ch   <= cmd_num_ch;
                pix      <= '0;
                ch       <= '0;
                // Empty jobs finish immediately without touching the engine
                job_done <= cmd_zero;
            end
            if (state == CAPT_CB) begin
                eng_bias  <= cb_bias;
                eng_scale <= cb_scale;
            end
            if (state == RUN && eng_done) begin
                out_data <= eng_result;
                out_pix  <= pix;
                out_ch   <= ch;
            end
            if (state == EMIT && out_ready && last)
                job_done <= 1'b1;
            if (state == ADVANCE && !last) begin
                if (ch_last) begin
                    ch  <= '0;
                    pix <= pix + PIX_W'(1);
                end else begin
                    ch <= ch + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_layer0_scheduler.sv
// Directed bench for layer0_scheduler with a behavioural MAC engine and
// registered activation/weight/bias tables.
module tb_layer0_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_num_pix = '0;
    logic [5:0]  cmd_num_ch = '0;
    logic [16:0] act_addr;
    logic [7:0]  act_data = '0;
    logic [10:0] w_addr;
    logic [7:0]  w_data = '0;
    logic [5:0]  cb_addr;
    logic [31:0] cb_bias = '0;
    logic [15:0] cb_scale = '0;
    logic        eng_start;
    logic [7:0]  eng_act, eng_w;
    logic [31:0] eng_bias;
    logic [15:0] eng_scale;
    logic [4:0]  eng_mac_index = '0;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [11:0] out_pix;
    logic [5:0]  out_ch;
    logic        busy, job_done;

    int errors = 0;
    int checks = 0;
    int mode = 0;

    layer0_scheduler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_num_pix(cmd_num_pix), .cmd_num_ch(cmd_num_ch),
        .act_addr(act_addr), .act_data(act_data),
        .w_addr(w_addr), .w_data(w_data),
        .cb_addr(cb_addr), .cb_bias(cb_bias), .cb_scale(cb_scale),
        .eng_start(eng_start), .eng_act(eng_act), .eng_w(eng_w),
        .eng_bias(eng_bias), .eng_scale(eng_scale),
        .eng_mac_index(eng_mac_index), .eng_done(eng_done),
        .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pix(out_pix), .out_ch(out_ch),
        .busy(busy), .job_done(job_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] act_f(int a);
        if (mode == 0) return 8'd1;
        return 8'(a % 7 - 3);
    endfunction

    function automatic logic [7:0] w_f(int a);
        if (mode == 0) return 8'd1;
        return 8'(a % 5 - 2);
    endfunction

    function automatic logic [31:0] bias_f(int c);
        if (mode == 0) return 32'd0;
        return 32'(c * 10 - 7);
    endfunction

    function automatic logic [15:0] scale_f(int c);
        return 16'(256 + (mode == 0 ? 0 : c));
    endfunction

    function automatic logic [7:0] exp_f(int p, int c);
        int s = 0;
        for (int i = 0; i < 27; i++)
            s += int'($signed(act_f(p * 27 + i))) * int'($signed(w_f(c * 27 + i)));
        s += int'($signed(bias_f(c)));
        return 8'(s);
    endfunction

    always @(posedge clk) begin
        act_data <= act_f(int'(act_addr));
        w_data   <= w_f(int'(w_addr));
        cb_bias  <= bias_f(int'(cb_addr));
        cb_scale <= scale_f(int'(cb_addr));
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!eng_start && n < 20) begin
            tick();
            n++;
        end
        if (!eng_start) check("start_timeout", 0, 1);
    endtask

    task automatic mac(input int p, input int c, input int cnt, output int acc);
        acc = 0;
        for (int i = 0; i < cnt; i++) begin
            eng_mac_index = 5'(i);
            #1;
            check("act_addr", act_addr, p * 27 + i);
            check("w_addr", w_addr, c * 27 + i);
            tick();
            if (i == 0) check("start_1cyc", eng_start, 0);
            acc += int'($signed(eng_act)) * int'($signed(eng_w));
        end
    endtask

    task automatic run_job(input int np, input int nc, input int stall_k, input bit spur);
        int n, acc, k;
        bit stable, lst;
        logic [7:0] d0;
        cmd_num_pix = 12'(np);
        cmd_num_ch  = 6'(nc);
        cmd_valid   = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        if (np == 0 || nc == 0) begin
            check("zero_done", job_done, 1);
            check("zero_busy", busy, 0);
            check("zero_start", eng_start, 0);
            tick();
            check("zero_done_1cyc", job_done, 0);
            check("zero_start2", eng_start, 0);
        end else begin
            k = 0;
            for (int p = 0; p < np; p++) begin
                for (int c = 0; c < nc; c++) begin
                    wait_start(n);
                    if (k == 0) check("start_lat", n + 1, 3);
                    else        check("start_gap", n, 3);
                    check("busy_run", busy, 1);
                    mac(p, c, 27, acc);
                    acc += int'($signed(eng_bias));
                    eng_result = 8'(acc);
                    eng_done = 1'b1;
                    tick();
                    eng_done = 1'b0;
                    check("out_valid", out_valid, 1);
                    check("out_data", out_data, exp_f(p, c));
                    check("out_pix", out_pix, p);
                    check("out_ch", out_ch, c);
                    check("eng_bias", eng_bias, bias_f(c));
                    check("eng_scale", eng_scale, scale_f(c));
                    if (k == stall_k) begin
                        stable = 1'b1;
                        d0 = out_data;
                        for (int s = 0; s < 10; s++) begin
                            eng_done = spur && (s == 2);
                            tick();
                            if (!out_valid || out_data != d0 || out_pix != 12'(p) ||
                                out_ch != 6'(c) || eng_start)
                                stable = 1'b0;
                        end
                        eng_done = 1'b0;
                        check("stall_stable", stable, 1);
                    end
                    lst = (p == np - 1) && (c == nc - 1);
                    out_ready = 1'b1;
                    tick();
                    out_ready = 1'b0;
                    check("job_done", job_done, lst);
                    check("ovalid_drop", out_valid, 0);
                    k++;
                end
            end
            tick();
            check("busy_end", busy, 0);
            check("done_1cyc", job_done, 0);
        end
    endtask

    initial begin
        int n, acc;
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_job_done", job_done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_eng_bias", eng_bias, 0);
        check("rst_eng_scale", eng_scale, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);

        mode = 0;
        run_job(1, 1, -1, 1'b0);

        mode = 1;
        run_job(2, 3, 4, 1'b1);

        run_job(0, 5, -1, 1'b0);
        run_job(3, 0, -1, 1'b0);

        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("spur_idle_busy", busy, 0);
        check("spur_idle_valid", out_valid, 0);

        cmd_num_pix = 12'd2;
        cmd_num_ch  = 6'd2;
        cmd_valid   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_start(n);
        mac(0, 0, 5, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_valid", out_valid, 0);
        check("midrun_ready", cmd_ready, 1);
        run_job(1, 1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
